// File: rtl/vga_timing_pkg.sv
// Shared screen geometry (snakePkg) plus the sync-decode helpers used by the VGA timing core.
package snakePkg;
   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;
   typedef struct packed {
      coord_t x;
      coord_t y;
   } pt2D;

   // 640x480 @ 60 Hz industry timing, in pixels and lines
   localparam int H_VIS_DEF = 640;
   localparam int H_FP_DEF  = 16;
   localparam int H_SW_DEF  = 96;
   localparam int H_BP_DEF  = 48;
   localparam int V_VIS_DEF = 480;
   localparam int V_FP_DEF  = 10;
   localparam int V_SW_DEF  = 2;
   localparam int V_BP_DEF  = 33;
endpackage

package vga_timing_pkg;
   import snakePkg::*;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic video_on;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

   typedef struct packed {
      coord_t h_vis;
      coord_t hs_lo;
      coord_t hs_len;
      coord_t v_vis;
      coord_t vs_lo;
      coord_t vs_len;
   } geom_t;

   // v lies in [lo, lo+len-1]; subtraction form avoids overflow near the top of the range
   function automatic logic in_span(coord_t v, coord_t lo, coord_t len);
      return (v >= lo) && ((v - lo) < len);
   endfunction

   function automatic sync_t decode(pt2D p, geom_t g);
      sync_t s;
      s.hsync    = ~in_span(p.x, g.hs_lo, g.hs_len);
      s.vsync    = ~in_span(p.y, g.vs_lo, g.vs_len);
      s.video_on = (p.x < g.h_vis) && (p.y < g.v_vis);
      return s;
   endfunction
endpackage

// File: rtl/vga_timing_if.sv
// Timing-generator bundle: pixel enable in, raster position and sync strobes out.
interface vga_timing_if;
   import snakePkg::*;

   logic   pix_en;
   coord_t ppc;
   coord_t plc;
   logic   hsync;
   logic   vsync;
   logic   video_on;
   logic   frame_tick;

   modport master (
      input  pix_en,
      output ppc, plc, hsync, vsync, video_on, frame_tick
   );

   modport slave (
      output pix_en,
      input  ppc, plc, hsync, vsync, video_on, frame_tick
   );
endinterface

// File: rtl/vga_timing_mod_counter.sv
// Modulo-MOD up-counter; resets to MOD-1 so the first enabled step lands on 0.
module mod_counter
   import snakePkg::*;
#(
   parameter int MOD = 800
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   en,
   output coord_t count,
   output logic   wrap
);
   localparam coord_t LAST = coord_t'(MOD - 1);

   coord_t count_q, count_d;

   assign wrap  = en && (count_q == LAST);
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      if (en) count_d = wrap ? '0 : count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= LAST;
      else        count_q <= count_d;
   end
endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: column/line counters with zero-skew registered sync, blanking and frame tick.
module vga_timing
   import snakePkg::*, vga_timing_pkg::*;
#(
   parameter int H_VIS = H_VIS_DEF,
   parameter int H_FP  = H_FP_DEF,
   parameter int H_SW  = H_SW_DEF,
   parameter int H_BP  = H_BP_DEF,
   parameter int V_VIS = V_VIS_DEF,
   parameter int V_FP  = V_FP_DEF,
   parameter int V_SW  = V_SW_DEF,
   parameter int V_BP  = V_BP_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   vga_timing_if.master vif
);
   localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

   localparam geom_t GEOM = '{
      h_vis:  coord_t'(H_VIS),
      hs_lo:  coord_t'(H_VIS + H_FP),
      hs_len: coord_t'(H_SW),
      v_vis:  coord_t'(V_VIS),
      vs_lo:  coord_t'(V_VIS + V_FP),
      vs_len: coord_t'(V_SW)
   };
   localparam coord_t V_LAST_VIS = coord_t'(V_VIS - 1);

   coord_t col, line;
   logic   col_wrap, line_wrap, line_en;
   pt2D    pos_nxt;
   sync_t  sync_q, sync_d;
   logic   frame_tick_q, frame_tick_d;

   assign line_en = vif.pix_en & col_wrap;

   mod_counter #(.MOD(H_TOT)) u_col (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (vif.pix_en),
      .count (col),
      .wrap  (col_wrap)
   );

   mod_counter #(.MOD(V_TOT)) u_line (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (line_en),
      .count (line),
      .wrap  (line_wrap)
   );

   // Decode the position the counters are about to present, so the sync
   // registers change on the very same edge as ppc/plc.
   always_comb begin
      pos_nxt = '{x: col, y: line};
      if (vif.pix_en) begin
         pos_nxt.x = col_wrap ? '0 : col + 1'b1;
         if (col_wrap) pos_nxt.y = line_wrap ? '0 : line + 1'b1;
      end
      sync_d       = vif.pix_en ? decode(pos_nxt, GEOM) : sync_q;
      frame_tick_d = line_en && (line == V_LAST_VIS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q       <= SYNC_IDLE;
         frame_tick_q <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign vif.ppc        = col;
   assign vif.plc        = line;
   assign vif.hsync      = sync_q.hsync;
   assign vif.vsync      = sync_q.vsync;
   assign vif.video_on   = sync_q.video_on;
   assign vif.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_vga_timing.sv
// Checks a default-timing and a shrunken-timing instance against a linear raster-index model.
module tb_vga_timing;
   logic clk = 1'b0;
   logic rst_n;
   logic pe;

   always #5 clk = ~clk;

   vga_timing_if vif0 ();
   vga_timing_if vif1 ();
   assign vif0.pix_en = pe;
   assign vif1.pix_en = pe;

   vga_timing u_dut (.clk(clk), .rst_n(rst_n), .vif(vif0));

   vga_timing #(
      .H_VIS(8), .H_FP(2), .H_SW(3), .H_BP(2),
      .V_VIS(6), .V_FP(2), .V_SW(2), .V_BP(3)
   ) u_sml (.clk(clk), .rst_n(rst_n), .vif(vif1));

   // Raster geometry of each instance: [0] standard 640x480, [1] small 15x13 raster
   int HV[2] = '{640, 8};
   int HF[2] = '{16, 2};
   int HS[2] = '{96, 3};
   int HB[2] = '{48, 2};
   int VV[2] = '{480, 6};
   int VF[2] = '{10, 2};
   int VS[2] = '{2, 2};
   int VB[2] = '{33, 3};

   // Model state: linear pixel index into the frame, and expected tick
   int p[2];
   int ft_exp[2];
   int total = 0;
   int bad   = 0;

   function automatic int htot(input int i);
      return HV[i] + HF[i] + HS[i] + HB[i];
   endfunction

   function automatic int vtot(input int i);
      return VV[i] + VF[i] + VS[i] + VB[i];
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_inst(input int i, input int x, input int y, input int hs,
                             input int vs, input int von, input int ft);
      int ex, ey, hlo, vlo;
      ex  = p[i] % htot(i);
      ey  = p[i] / htot(i);
      hlo = HV[i] + HF[i];
      vlo = VV[i] + VF[i];
      chk($sformatf("u%0d.ppc", i), x, ex);
      chk($sformatf("u%0d.plc", i), y, ey);
      chk($sformatf("u%0d.hsync@%0d", i, ex), hs, (ex >= hlo && ex < hlo + HS[i]) ? 0 : 1);
      chk($sformatf("u%0d.vsync@%0d", i, ey), vs, (ey >= vlo && ey < vlo + VS[i]) ? 0 : 1);
      chk($sformatf("u%0d.video_on", i), von, (ex < HV[i] && ey < VV[i]) ? 1 : 0);
      chk($sformatf("u%0d.frame_tick", i), ft, ft_exp[i]);
   endtask

   task automatic check_all();
      check_inst(0, int'(vif0.ppc), int'(vif0.plc), int'(vif0.hsync),
                 int'(vif0.vsync), int'(vif0.video_on), int'(vif0.frame_tick));
      check_inst(1, int'(vif1.ppc), int'(vif1.plc), int'(vif1.hsync),
                 int'(vif1.vsync), int'(vif1.video_on), int'(vif1.frame_tick));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         p[i]      = htot(i) * vtot(i) - 1;
         ft_exp[i] = 0;
      end
   endtask

   // One clk: drive pix_en, let the edge happen, advance the model, check 1 time unit later
   task automatic step(input logic en);
      pe = en;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         ft_exp[i] = 0;
         if (rst_n && en) begin
            p[i]      = (p[i] + 1) % (htot(i) * vtot(i));
            ft_exp[i] = (p[i] == VV[i] * htot(i)) ? 1 : 0;
         end
      end
      #1;
      check_all();
   endtask

   initial begin
      int found;
      rst_n = 1'b0;
      pe    = 1'b0;
      model_reset();

      // Reset state, with pix_en toggling underneath
      repeat (3) step(1'b1);
      chk("rst.ppc", int'(vif0.ppc), 799);
      chk("rst.plc", int'(vif0.plc), 524);
      chk("rst.video_on", int'(vif0.video_on), 0);

      rst_n = 1'b1;
      step(1'b1);
      chk("first.ppc", int'(vif0.ppc), 0);
      chk("first.plc", int'(vif0.plc), 0);
      chk("first.video_on", int'(vif0.video_on), 1);
      chk("first.hsync", int'(vif0.hsync), 1);
      chk("first.vsync", int'(vif0.vsync), 1);

      // Continuous enable: two full default lines, many small frames and wraps
      repeat (1700) step(1'b1);

      // 50% enable duty: outputs hold on the idle cycles, tick stays one clk wide
      repeat (900) begin
         step(1'b1);
         step(1'b0);
      end

      // Random enable pattern
      repeat (3000) step($urandom_range(0, 1) != 0);

      // Advance the small raster to its frame tick, then reset asynchronously mid-cycle
      found = 0;
      for (int k = 0; k < 1000 && found == 0; k++) begin
         step(1'b1);
         if (p[1] == VV[1] * htot(1)) found = 1;
      end
      chk("seek_tick", found, 1);
      chk("pre_rst.tick", int'(vif1.frame_tick), 1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("async_rst.ppc", int'(vif1.ppc), 14);
      chk("async_rst.tick", int'(vif1.frame_tick), 0);
      repeat (3) step(1'b1);

      rst_n = 1'b1;
      step(1'b1);
      chk("restart.ppc", int'(vif0.ppc), 0);
      chk("restart.plc", int'(vif0.plc), 0);
      chk("restart.video_on", int'(vif1.video_on), 1);

      repeat (400) step($urandom_range(0, 3) != 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
